// File: rtl/npc_pkg.sv
// Shared NPC core constants and the commit-record type exported to the GPR mirror and difftest.
package npc_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wdata;
    } commit_rec_t;

endpackage

// File: rtl/gpr_file_if.sv
// Bundle of read, issue, write-back, flush and commit signals between the core and the register file.
interface gpr_file_if;
    import npc_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic [XLEN-1:0]       wb_pc;
    logic                  flush;
    logic                  commit_valid;
    logic [XLEN-1:0]       commit_pc;
    logic [REG_ADDR_W-1:0] commit_rd;
    logic [XLEN-1:0]       commit_wdata;
    logic [NREG*XLEN-1:0]  regs_flat;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd,
               wb_valid, wb_rd, wb_data, wb_pc, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy,
               commit_valid, commit_pc, commit_rd, commit_wdata, regs_flat
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd,
               wb_valid, wb_rd, wb_data, wb_pc, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy,
               commit_valid, commit_pc, commit_rd, commit_wdata, regs_flat
    );

endinterface

// File: rtl/gpr_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write-back or flush.
module gpr_scoreboard
    import npc_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_issueValid,
    input  logic [REG_ADDR_W-1:0] i_issueRd,
    input  logic                  i_wbValid,
    input  logic [REG_ADDR_W-1:0] i_wbRd,
    input  logic                  i_flush,
    input  logic [REG_ADDR_W-1:0] i_rs1Addr,
    input  logic [REG_ADDR_W-1:0] i_rs2Addr,
    output logic                  o_rs1Busy,
    output logic                  o_rs2Busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busyNext;

    // Later assignments take priority: a new producer overrides a retiring one, flush overrides all.
    always_comb begin
        w_busyNext = r_busy;
        if (i_wbValid)    w_busyNext[i_wbRd]    = 1'b0;
        if (i_issueValid) w_busyNext[i_issueRd] = 1'b1;
        if (i_flush)      w_busyNext            = '0;
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busyNext;
    end

    // A same-cycle write-back is served by the bypass, so it is not a stall.
    assign o_rs1Busy = r_busy[i_rs1Addr] && !(i_wbValid && i_wbRd == i_rs1Addr);
    assign o_rs2Busy = r_busy[i_rs2Addr] && !(i_wbValid && i_wbRd == i_rs2Addr);

    a_noIssueToBusy : assert property (@(posedge clock) disable iff (reset)
        !(i_issueValid && r_busy[i_issueRd] && i_issueRd != '0
          && !(i_wbValid && i_wbRd == i_issueRd)))
        else $error("issue to a register that already has a pending write");

endmodule

// File: rtl/gpr_file.sv
// Architectural integer register file: storage, write-back bypass reads and the delayed commit record.
module gpr_file
    import npc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    gpr_file_if.slave   bus
);

    logic [XLEN-1:0]      r_rf [1:NREG-1];
    commit_rec_t          r_commit;
    logic [XLEN-1:0]      w_rs1Data;
    logic [XLEN-1:0]      w_rs2Data;
    logic [NREG*XLEN-1:0] w_flat;

    // x0 has no storage; flush intentionally leaves write-back untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) r_rf[i] <= '0;
        end else if (bus.wb_valid && bus.wb_rd != '0) begin
            r_rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_commit <= '0;
        end else begin
            r_commit.valid <= bus.wb_valid;
            if (bus.wb_valid) begin
                r_commit.pc    <= bus.wb_pc;
                r_commit.rd    <= bus.wb_rd;
                r_commit.wdata <= (bus.wb_rd == '0) ? '0 : bus.wb_data;
            end
        end
    end

    always_comb begin
        w_rs1Data = '0;
        if (bus.rs1_addr != '0) begin
            if (bus.wb_valid && bus.wb_rd == bus.rs1_addr) w_rs1Data = bus.wb_data;
            else                                           w_rs1Data = r_rf[bus.rs1_addr];
        end
    end

    always_comb begin
        w_rs2Data = '0;
        if (bus.rs2_addr != '0) begin
            if (bus.wb_valid && bus.wb_rd == bus.rs2_addr) w_rs2Data = bus.wb_data;
            else                                           w_rs2Data = r_rf[bus.rs2_addr];
        end
    end

    always_comb begin
        w_flat = '0;
        for (int i = 1; i < NREG; i++) w_flat[i*XLEN +: XLEN] = r_rf[i];
    end

    gpr_scoreboard u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .i_issueValid (bus.issue_valid),
        .i_issueRd    (bus.issue_rd),
        .i_wbValid    (bus.wb_valid),
        .i_wbRd       (bus.wb_rd),
        .i_flush      (bus.flush),
        .i_rs1Addr    (bus.rs1_addr),
        .i_rs2Addr    (bus.rs2_addr),
        .o_rs1Busy    (bus.rs1_busy),
        .o_rs2Busy    (bus.rs2_busy)
    );

    assign bus.rs1_data     = w_rs1Data;
    assign bus.rs2_data     = w_rs2Data;
    assign bus.regs_flat    = w_flat;
    assign bus.commit_valid = r_commit.valid;
    assign bus.commit_pc    = r_commit.pc;
    assign bus.commit_rd    = r_commit.rd;
    assign bus.commit_wdata = r_commit.wdata;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: directed scenarios plus randomized traffic against an array-based register file model.
module tb_gpr_file;

    logic clock;
    logic reset;
    int   nCompared;
    int   nMismatched;

    gpr_file_if gif ();

    gpr_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (gif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference state: plain arrays updated with the architectural rules at each clock edge.
    logic [63:0] mRf   [32];
    bit          mBusy [32];
    bit          mCv;
    logic [63:0] mCpc;
    logic [4:0]  mCrd;
    logic [63:0] mCwd;

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mRf[i]   = '0;
            mBusy[i] = 1'b0;
        end
        mCv = 1'b0; mCpc = '0; mCrd = '0; mCwd = '0;
    endtask

    function automatic logic [63:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (gif.wb_valid && gif.wb_rd == a) return gif.wb_data;
        return mRf[a];
    endfunction

    function automatic bit expBusy(input logic [4:0] a);
        return mBusy[a] && !(gif.wb_valid && gif.wb_rd == a);
    endfunction

    // Returns the index of the first register whose flat slice disagrees with the model, or -1.
    function automatic int flatBadIdx();
        for (int i = 0; i < 32; i++)
            if (gif.regs_flat[i*64 +: 64] !== ((i == 0) ? 64'd0 : mRf[i])) return i;
        return -1;
    endfunction

    task automatic setIdle();
        gif.rs1_addr = '0; gif.rs2_addr = '0;
        gif.issue_valid = 1'b0; gif.issue_rd = '0;
        gif.wb_valid = 1'b0; gif.wb_rd = '0; gif.wb_data = '0; gif.wb_pc = '0;
        gif.flush = 1'b0;
    endtask

    task automatic tick();
        logic iv, wv, fl;
        logic [4:0] ir, wr;
        logic [63:0] wd, wp;
        iv = gif.issue_valid; ir = gif.issue_rd; fl = gif.flush;
        wv = gif.wb_valid; wr = gif.wb_rd; wd = gif.wb_data; wp = gif.wb_pc;
        @(posedge clock);
        for (int i = 1; i < 32; i++) begin
            if (fl)                    mBusy[i] = 1'b0;
            else if (iv && ir == i)    mBusy[i] = 1'b1;
            else if (wv && wr == i)    mBusy[i] = 1'b0;
        end
        if (wv && wr != 5'd0) mRf[wr] = wd;
        mCv = wv;
        if (wv) begin
            mCpc = wp; mCrd = wr; mCwd = (wr == 5'd0) ? 64'd0 : wd;
        end
        #1;
    endtask

    task automatic test_reset();
        int bad;
        setIdle();
        reset = 1'b1;
        modelReset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        bad = flatBadIdx();
        nCompared++;
        if (bad >= 0) begin
            nMismatched++;
            $display("[TB] FAIL reset_flat reg %0d got %h want 0", bad, gif.regs_flat[bad*64 +: 64]);
        end
        for (int a = 0; a < 32; a++) begin
            gif.rs1_addr = a[4:0]; gif.rs2_addr = 5'(31 - a);
            #1;
            nCompared++;
            if (gif.rs1_data !== 64'd0 || gif.rs2_data !== 64'd0) begin
                nMismatched++;
                $display("[TB] FAIL reset_read addr %0d got %h/%h want 0", a, gif.rs1_data, gif.rs2_data);
            end
            nCompared++;
            if (gif.rs1_busy !== 1'b0 || gif.rs2_busy !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_busy addr %0d got %b/%b want 0", a, gif.rs1_busy, gif.rs2_busy);
            end
        end
        nCompared++;
        if (gif.commit_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_commit_valid got %b want 0", gif.commit_valid);
        end
        setIdle();
    endtask

    task automatic test_write_read();
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd5;
        gif.wb_data = 64'hDEAD_BEEF_0000_0001; gif.wb_pc = 64'h8000_0000;
        gif.rs1_addr = 5'd5;
        #1;
        nCompared++;
        if (gif.rs1_data !== 64'hDEAD_BEEF_0000_0001) begin
            nMismatched++;
            $display("[TB] FAIL wr_bypass got %h want %h", gif.rs1_data, 64'hDEAD_BEEF_0000_0001);
        end
        tick();
        setIdle();
        nCompared++;
        if (gif.commit_valid !== 1'b1 || gif.commit_pc !== 64'h8000_0000 || gif.commit_rd !== 5'd5
            || gif.commit_wdata !== 64'hDEAD_BEEF_0000_0001) begin
            nMismatched++;
            $display("[TB] FAIL wr_commit got v=%b pc=%h rd=%0d wd=%h want v=1 pc=80000000 rd=5 wd=deadbeef00000001",
                     gif.commit_valid, gif.commit_pc, gif.commit_rd, gif.commit_wdata);
        end
        nCompared++;
        if (gif.regs_flat[5*64 +: 64] !== 64'hDEAD_BEEF_0000_0001) begin
            nMismatched++;
            $display("[TB] FAIL wr_flat x5 got %h want deadbeef00000001", gif.regs_flat[5*64 +: 64]);
        end
        tick();
        nCompared++;
        if (gif.commit_valid !== 1'b0 || gif.commit_pc !== 64'h8000_0000 || gif.commit_rd !== 5'd5) begin
            nMismatched++;
            $display("[TB] FAIL wr_commit_hold got v=%b pc=%h rd=%0d want v=0 pc=80000000 rd=5",
                     gif.commit_valid, gif.commit_pc, gif.commit_rd);
        end
    endtask

    task automatic test_x0_write();
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd0;
        gif.wb_data = 64'hFFFF_FFFF_FFFF_FFFF; gif.wb_pc = 64'h8000_0004;
        gif.rs1_addr = 5'd0;
        #1;
        nCompared++;
        if (gif.rs1_data !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL x0_read got %h want 0", gif.rs1_data);
        end
        tick();
        setIdle();
        nCompared++;
        if (gif.regs_flat[63:0] !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL x0_flat got %h want 0", gif.regs_flat[63:0]);
        end
        nCompared++;
        if (gif.commit_valid !== 1'b1 || gif.commit_rd !== 5'd0 || gif.commit_wdata !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL x0_commit got v=%b rd=%0d wd=%h want v=1 rd=0 wd=0",
                     gif.commit_valid, gif.commit_rd, gif.commit_wdata);
        end
    endtask

    task automatic test_scoreboard();
        gif.issue_valid = 1'b1; gif.issue_rd = 5'd7;
        tick();
        setIdle();
        gif.rs2_addr = 5'd7;
        #1;
        nCompared++;
        if (gif.rs2_busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sb_set got %b want 1", gif.rs2_busy);
        end
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd7; gif.wb_data = 64'h0123_4567_89AB_CDEF; gif.wb_pc = 64'h8000_0008;
        #1;
        nCompared++;
        if (gif.rs2_busy !== 1'b0 || gif.rs2_data !== 64'h0123_4567_89AB_CDEF) begin
            nMismatched++;
            $display("[TB] FAIL sb_wb_cycle got busy=%b data=%h want busy=0 data=0123456789abcdef",
                     gif.rs2_busy, gif.rs2_data);
        end
        tick();
        setIdle();
        gif.rs2_addr = 5'd7;
        #1;
        nCompared++;
        if (gif.rs2_busy !== 1'b0 || gif.rs2_data !== 64'h0123_4567_89AB_CDEF) begin
            nMismatched++;
            $display("[TB] FAIL sb_cleared got busy=%b data=%h want busy=0 data=0123456789abcdef",
                     gif.rs2_busy, gif.rs2_data);
        end
        setIdle();
    endtask

    task automatic test_issue_wb_same();
        gif.issue_valid = 1'b1; gif.issue_rd = 5'd9;
        tick();
        setIdle();
        gif.issue_valid = 1'b1; gif.issue_rd = 5'd9;
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd9; gif.wb_data = 64'h9999_AAAA_BBBB_CCCC; gif.wb_pc = 64'h8000_000C;
        tick();
        setIdle();
        gif.rs1_addr = 5'd9;
        #1;
        nCompared++;
        if (gif.rs1_busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL same_busy got %b want 1", gif.rs1_busy);
        end
        nCompared++;
        if (gif.rs1_data !== 64'h9999_AAAA_BBBB_CCCC) begin
            nMismatched++;
            $display("[TB] FAIL same_data got %h want 9999aaaabbbbcccc", gif.rs1_data);
        end
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd9; gif.wb_data = 64'h9; gif.wb_pc = 64'h8000_0010;
        tick();
        setIdle();
    endtask

    task automatic test_flush();
        gif.issue_valid = 1'b1; gif.issue_rd = 5'd3;
        tick();
        gif.issue_rd = 5'd4;
        tick();
        setIdle();
        gif.flush = 1'b1;
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd3; gif.wb_data = 64'h42; gif.wb_pc = 64'h8000_0014;
        tick();
        setIdle();
        gif.rs1_addr = 5'd3; gif.rs2_addr = 5'd4;
        #1;
        nCompared++;
        if (gif.rs1_busy !== 1'b0 || gif.rs2_busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL flush_busy got %b/%b want 0/0", gif.rs1_busy, gif.rs2_busy);
        end
        nCompared++;
        if (gif.rs1_data !== 64'h42 || gif.regs_flat[3*64 +: 64] !== 64'h42) begin
            nMismatched++;
            $display("[TB] FAIL flush_wb got rd=%h flat=%h want 42", gif.rs1_data, gif.regs_flat[3*64 +: 64]);
        end
        nCompared++;
        if (gif.commit_valid !== 1'b1 || gif.commit_rd !== 5'd3) begin
            nMismatched++;
            $display("[TB] FAIL flush_commit got v=%b rd=%0d want v=1 rd=3", gif.commit_valid, gif.commit_rd);
        end
        setIdle();
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 400; c++) begin
            gif.rs1_addr    = 5'($urandom_range(0, 31));
            gif.rs2_addr    = 5'($urandom_range(0, 31));
            gif.wb_valid    = ($urandom_range(0, 1) == 1);
            gif.wb_rd       = 5'($urandom_range(0, 31));
            gif.wb_data     = {$urandom(), $urandom()};
            gif.wb_pc       = {$urandom(), $urandom()};
            gif.issue_valid = ($urandom_range(0, 4) < 2);
            gif.issue_rd    = 5'($urandom_range(0, 31));
            gif.flush       = ($urandom_range(0, 19) == 0);
            if (gif.issue_valid && gif.issue_rd != 5'd0 && mBusy[gif.issue_rd]
                && !(gif.wb_valid && gif.wb_rd == gif.issue_rd))
                gif.issue_valid = 1'b0;
            #1;
            nCompared++;
            if (gif.rs1_data !== expRead(gif.rs1_addr) || gif.rs2_data !== expRead(gif.rs2_addr)) begin
                nMismatched++;
                $display("[TB] FAIL rnd_read cyc %0d a=%0d/%0d got %h/%h want %h/%h", c, gif.rs1_addr,
                         gif.rs2_addr, gif.rs1_data, gif.rs2_data, expRead(gif.rs1_addr), expRead(gif.rs2_addr));
            end
            nCompared++;
            if (gif.rs1_busy !== expBusy(gif.rs1_addr) || gif.rs2_busy !== expBusy(gif.rs2_addr)) begin
                nMismatched++;
                $display("[TB] FAIL rnd_busy cyc %0d a=%0d/%0d got %b/%b want %b/%b", c, gif.rs1_addr,
                         gif.rs2_addr, gif.rs1_busy, gif.rs2_busy, expBusy(gif.rs1_addr), expBusy(gif.rs2_addr));
            end
            tick();
            nCompared++;
            if (gif.commit_valid !== mCv || gif.commit_pc !== mCpc || gif.commit_rd !== mCrd
                || gif.commit_wdata !== mCwd) begin
                nMismatched++;
                $display("[TB] FAIL rnd_commit cyc %0d got v=%b pc=%h rd=%0d wd=%h want v=%b pc=%h rd=%0d wd=%h", c,
                         gif.commit_valid, gif.commit_pc, gif.commit_rd, gif.commit_wdata, mCv, mCpc, mCrd, mCwd);
            end
            bad = flatBadIdx();
            nCompared++;
            if (bad >= 0) begin
                nMismatched++;
                $display("[TB] FAIL rnd_flat cyc %0d reg %0d got %h want %h", c, bad,
                         gif.regs_flat[bad*64 +: 64], (bad == 0) ? 64'd0 : mRf[bad]);
            end
        end
        setIdle();
    endtask

    task automatic test_reset_midstream();
        int bad;
        gif.issue_valid = 1'b1; gif.issue_rd = 5'd12;
        gif.wb_valid = 1'b1; gif.wb_rd = 5'd13; gif.wb_data = 64'h1313; gif.wb_pc = 64'h8000_0100;
        tick();
        setIdle();
        gif.rs1_addr = 5'd12; gif.rs2_addr = 5'd13;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        bad = flatBadIdx();
        nCompared++;
        if (bad >= 0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_flat reg %0d got %h want 0", bad, gif.regs_flat[bad*64 +: 64]);
        end
        nCompared++;
        if (gif.commit_valid !== 1'b0 || gif.commit_pc !== 64'd0 || gif.commit_rd !== 5'd0
            || gif.commit_wdata !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_commit got v=%b pc=%h rd=%0d wd=%h want all 0",
                     gif.commit_valid, gif.commit_pc, gif.commit_rd, gif.commit_wdata);
        end
        nCompared++;
        if (gif.rs1_busy !== 1'b0 || gif.rs2_data !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_out got busy=%b data=%h want 0/0", gif.rs1_busy, gif.rs2_data);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b1;
        setIdle();
        modelReset();
        test_reset();
        test_write_read();
        test_x0_write();
        test_scoreboard();
        test_issue_wb_same();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
